// File: rtl/wb_bank_arbiter.sv
// wb_bank_arbiter: routes core masters or the host onto address-selected memory banks with per-bank round-robin,
// ack timeout and sticky end-of-execution detection.
module wb_bank_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_BANKS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BANK_SEL_LSB   = 31,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  core_sel_i,
  input  logic [NUM_MASTERS-1:0]                                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                                m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]                     m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]                     m_data_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]                     m_data_o,
  output logic [NUM_MASTERS-1:0]                                m_ack_o,
  output logic [NUM_MASTERS-1:0]                                m_err_o,
  input  logic                                                  h_cyc_i,
  input  logic                                                  h_stb_i,
  input  logic                                                  h_we_i,
  input  logic [ADDR_WIDTH-1:0]                                 h_addr_i,
  input  logic [DATA_WIDTH-1:0]                                 h_data_i,
  output logic [DATA_WIDTH-1:0]                                 h_data_o,
  output logic                                                  h_ack_o,
  output logic                                                  h_err_o,
  output logic [NUM_BANKS-1:0]                                  b_cyc_o,
  output logic [NUM_BANKS-1:0]                                  b_stb_o,
  output logic [NUM_BANKS-1:0]                                  b_we_o,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]                       b_addr_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]                       b_data_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]                       b_data_i,
  input  logic [NUM_BANKS-1:0]                                  b_ack_i,
  input  logic [ADDR_WIDTH-1:0]                                 end_addr_i,
  input  logic [ADDR_WIDTH-1:0]                                 end_mask_i,
  input  logic                                                  clear_finish_i,
  output logic                                                  finish_o,
  output logic [(NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1)-1:0] finish_master_o
);
  localparam int NM = NUM_MASTERS;
  localparam int NB = NUM_BANKS;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int FW = NM > 1 ? $clog2(NM) : 1;
  localparam int OW = $clog2(NM + 1);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [NB-1:0] state;
  logic [OW-1:0] owner [NB];
  logic [CW-1:0] cnt [NB];
  logic [FW-1:0] rr [NB];
  logic [NB-1:0] any_req, live, ack_fwd, err_fwd;
  logic [OW-1:0] win [NB];
  logic [NM-1:0] hit;
  logic [FW-1:0] hit_idx, idx, o;
  logic          host, oc, os, owe;
  logic [AW-1:0] oa;
  logic [DW-1:0] od;
  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] addr);
    return (NB == 1) ? '0 : addr[BANK_SEL_LSB +: BW];
  endfunction
  // Owner index NM denotes the host port.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_data_o = '0;
    h_ack_o = 1'b0;
    h_err_o = 1'b0;
    h_data_o = '0;
    b_cyc_o = '0;
    b_stb_o = '0;
    b_we_o = '0;
    b_addr_o = '0;
    b_data_o = '0;
    hit = '0;
    idx = '0;
    o = '0;
    host = 1'b0;
    oc = 1'b0;
    os = 1'b0;
    owe = 1'b0;
    oa = '0;
    od = '0;
    for (int k = 0; k < NB; k++) begin
      any_req[k] = 1'b0;
      win[k] = '0;
      for (int j = 0; j < NM; j++) begin
        idx = FW'((int'(rr[k]) + j) % NM);
        if (!any_req[k] && core_sel_i && m_cyc_i[idx] && m_stb_i[idx] &&
            bank_of(m_addr_i[idx*AW +: AW]) == BW'(k)) begin
          any_req[k] = 1'b1;
          win[k] = OW'(idx);
        end
      end
      if (h_cyc_i && h_stb_i && !core_sel_i && bank_of(h_addr_i) == BW'(k)) begin
        any_req[k] = 1'b1;
        win[k] = OW'(NM);
      end
      host = owner[k] == OW'(NM);
      o = host ? '0 : FW'(owner[k]);
      oc = host ? h_cyc_i : m_cyc_i[o];
      os = host ? h_stb_i : m_stb_i[o];
      owe = host ? h_we_i : m_we_i[o];
      oa = host ? h_addr_i : m_addr_i[o*AW +: AW];
      od = host ? h_data_i : m_data_i[o*DW +: DW];
      live[k] = state[k] == BUSY && oc;
      ack_fwd[k] = live[k] && b_ack_i[k];
      err_fwd[k] = live[k] && !b_ack_i[k] && TIMEOUT_CYCLES != 0 && cnt[k] == CW'(TIMEOUT_CYCLES);
      b_cyc_o[k] = live[k] && !err_fwd[k];
      b_stb_o[k] = b_cyc_o[k] && os;
      b_we_o[k] = b_cyc_o[k] && owe;
      b_addr_o[k*AW +: AW] = b_cyc_o[k] ? oa : '0;
      b_data_o[k*DW +: DW] = b_cyc_o[k] ? od : '0;
      if (host) begin
        h_ack_o = h_ack_o | ack_fwd[k];
        h_err_o = h_err_o | err_fwd[k];
        if (ack_fwd[k]) h_data_o = b_data_i[k*DW +: DW];
      end else begin
        if (err_fwd[k]) m_err_o[o] = 1'b1;
        if (ack_fwd[k]) begin
          m_ack_o[o] = 1'b1;
          m_data_o[o*DW +: DW] = b_data_i[k*DW +: DW];
          hit[o] = (oa & end_mask_i) == (end_addr_i & end_mask_i);
        end
      end
    end
    hit_idx = '0;
    for (int i = NM - 1; i >= 0; i--) if (hit[i]) hit_idx = FW'(i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
      finish_o <= 1'b0;
      finish_master_o <= '0;
      for (int k = 0; k < NB; k++) begin
        owner[k] <= '0;
        cnt[k] <= '0;
        rr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (state[k] == IDLE) begin
          if (any_req[k]) begin
            state[k] <= BUSY;
            owner[k] <= win[k];
            cnt[k] <= '0;
            if (win[k] != OW'(NM)) rr[k] <= FW'((int'(win[k]) + 1) % NM);
          end
        end else if (!live[k] || ack_fwd[k] || err_fwd[k]) state[k] <= IDLE;
        else cnt[k] <= cnt[k] + 1'b1;
      end
      if (clear_finish_i) finish_o <= 1'b0;
      else if (!finish_o && |hit) begin
        finish_o <= 1'b1;
        finish_master_o <= hit_idx;
      end
    end
  end
endmodule

// File: tb/tb_wb_bank_arbiter.sv
// tb_wb_bank_arbiter: vector table plus hand sequences; responses are checked against a per-requester scoreboard.
module tb_wb_bank_arbiter;
  localparam int NM = 2, NB = 2, AW = 32, DW = 32, T = 8;
  logic clk = 0, rst = 1, core_sel = 1, clr = 0;
  logic c[3], s[3], w[3];
  logic [31:0] a[3], d[3];
  logic [NM-1:0] m_cyc, m_stb, m_we, m_ack, m_err;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata, m_rdata;
  logic [DW-1:0] h_rdata;
  logic h_ack, h_err, finish;
  logic [NB-1:0] b_cyc, b_stb, b_we, b_ack, ack_q, ack_en;
  logic [NB*AW-1:0] b_addr;
  logic [NB*DW-1:0] b_wdata, b_rdata;
  logic [31:0] end_addr, end_mask;
  logic [0:0] finish_m;
  assign m_cyc = {c[1], c[0]};
  assign m_stb = {s[1], s[0]};
  assign m_we = {w[1], w[0]};
  assign m_addr = {a[1], a[0]};
  assign m_wdata = {d[1], d[0]};
  assign b_rdata = {32'hCAFE0001, 32'hDEADBEEF};
  assign b_ack = ack_q;
  wb_bank_arbiter #(.NUM_MASTERS(NM), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .BANK_SEL_LSB(31), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .core_sel_i(core_sel),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_wdata),
    .m_data_o(m_rdata), .m_ack_o(m_ack), .m_err_o(m_err),
    .h_cyc_i(c[2]), .h_stb_i(s[2]), .h_we_i(w[2]), .h_addr_i(a[2]), .h_data_i(d[2]),
    .h_data_o(h_rdata), .h_ack_o(h_ack), .h_err_o(h_err),
    .b_cyc_o(b_cyc), .b_stb_o(b_stb), .b_we_o(b_we), .b_addr_o(b_addr), .b_data_o(b_wdata),
    .b_data_i(b_rdata), .b_ack_i(b_ack),
    .end_addr_i(end_addr), .end_mask_i(end_mask), .clear_finish_i(clr),
    .finish_o(finish), .finish_master_o(finish_m));
  always #5 clk = ~clk;
  // Bank model: acks one cycle after it first sees a strobe, when enabled.
  always_ff @(posedge clk or posedge rst)
    if (rst) ack_q <= '0;
    else ack_q <= b_stb & ~ack_q & ack_en;
  typedef struct packed {logic err; logic [31:0] data;} rsp_t;
  typedef struct {int who; logic cs; logic [31:0] addr; logic we; logic [31:0] wd; logic [1:0] bcyc; logic [31:0] rd;} vec_t;
  rsp_t exp_q[3][$];
  rsp_t e;
  int checks = 0, passes = 0;
  int order[$];
  bit rec = 0;
  vec_t v[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic ack, err;
      logic [31:0] dat;
      ack = i < 2 ? m_ack[i] : h_ack;
      err = i < 2 ? m_err[i] : h_err;
      dat = i == 0 ? m_rdata[31:0] : i == 1 ? m_rdata[63:32] : h_rdata;
      if (ack || err) begin
        if (exp_q[i].size() == 0) chk($sformatf("unexpected_rsp%0d", i), {62'd0, err, ack}, 64'd0);
        else begin
          e = exp_q[i].pop_front();
          chk($sformatf("rsp%0d", i), {31'd0, err, dat}, {31'd0, e.err, e.data});
        end
        if (rec && ack && i < 2) order.push_back(i);
      end
    end
  end
  task automatic start(input int i, input logic [31:0] addr, input logic we, input logic [31:0] wd);
    @(posedge clk); #1;
    c[i] = 1; s[i] = 1; w[i] = we; a[i] = addr; d[i] = wd;
  endtask
  task automatic stop(input int i);
    @(posedge clk); #1;
    c[i] = 0; s[i] = 0; w[i] = 0;
  endtask
  task automatic wait_done(input int i);
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = i < 2 ? (m_ack[i] | m_err[i]) : (h_ack | h_err);
    end
    if (!got) begin
      checks++;
      $display("FAIL wait_done%0d: got no response expected ack or err", i);
    end
  endtask
  task automatic push(input int i, input logic err, input logic [31:0] data);
    exp_q[i].push_back({err, data});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int early, bk;
    for (int i = 0; i < 3; i++) begin c[i] = 0; s[i] = 0; w[i] = 0; a[i] = 0; d[i] = 0; end
    ack_en = 2'b11; end_addr = 32'h0000_0FFC; end_mask = 32'hFFFF_FFFF;
    v[0] = '{0, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 2'b01, 32'hDEADBEEF};
    v[1] = '{1, 1'b1, 32'h8000_0020, 1'b0, 32'h0, 2'b10, 32'hCAFE0001};
    v[2] = '{0, 1'b1, 32'h8000_0040, 1'b1, 32'h1234, 2'b10, 32'hCAFE0001};
    v[3] = '{1, 1'b1, 32'h0000_0080, 1'b1, 32'h5678, 2'b01, 32'hDEADBEEF};
    v[4] = '{2, 1'b0, 32'h0000_0300, 1'b0, 32'h0, 2'b01, 32'hDEADBEEF};
    repeat (2) @(negedge clk);
    chk("reset_bank", {b_cyc, b_stb, b_we}, 0);
    chk("reset_rsp", {m_ack, m_err, h_ack, h_err, finish}, 0);
    @(posedge clk); #1 rst = 0;
    foreach (v[n]) begin
      core_sel = v[n].cs;
      push(v[n].who, 1'b0, v[n].rd);
      start(v[n].who, v[n].addr, v[n].we, v[n].wd);
      @(negedge clk);
      chk("no_comb_grant", b_cyc, 0);
      @(negedge clk);
      bk = int'(v[n].bcyc[1]);
      chk("grant_bcyc", b_cyc, v[n].bcyc);
      chk("bank_addr", b_addr[bk*32 +: 32], v[n].addr);
      chk("bank_we", b_we[bk], v[n].we);
      chk("bank_wdata", b_wdata[bk*32 +: 32], v[n].wd);
      wait_done(v[n].who);
      stop(v[n].who);
    end
    core_sel = 1;
    rec = 1;
    fork
      for (int r = 0; r < 4; r++) begin push(0, 1'b0, 32'hDEADBEEF); start(0, 32'h8, 1'b0, 0); wait_done(0); end
      for (int r = 0; r < 4; r++) begin push(1, 1'b0, 32'hDEADBEEF); start(1, 32'hC, 1'b0, 0); wait_done(1); end
    join
    fork stop(0); stop(1); join
    rec = 0;
    chk("rr_count", order.size(), 8);
    for (int j = 1; j < order.size(); j++) chk("rr_alternate", order[j], 1 - order[j-1]);
    push(0, 1'b0, 32'hDEADBEEF);
    push(1, 1'b0, 32'hCAFE0001);
    fork start(0, 32'h0000_0100, 1'b0, 0); start(1, 32'h8000_0100, 1'b0, 0); join
    @(negedge clk); @(negedge clk);
    chk("concurrent_grant", b_cyc, 2'b11);
    fork wait_done(0); wait_done(1); join
    fork stop(0); stop(1); join
    ack_en[0] = 0;
    push(0, 1'b1, 32'h0);
    start(0, 32'h0000_0044, 1'b0, 0);
    @(negedge clk); @(negedge clk);
    chk("timeout_grant", b_cyc[0], 1);
    early = 0;
    for (int n = 1; n < T; n++) begin
      @(negedge clk);
      if (m_err[0] | m_ack[0] | !b_cyc[0]) early++;
    end
    chk("timeout_not_early", early, 0);
    @(negedge clk);
    chk("timeout_err", m_err[0], 1);
    chk("timeout_bcyc_drop", b_cyc[0], 0);
    chk("timeout_no_ack", m_ack[0], 0);
    stop(0);
    @(negedge clk);
    chk("timeout_err_pulse", m_err[0], 0);
    ack_en[0] = 1;
    chk("finish_initial", finish, 0);
    push(1, 1'b0, 32'hDEADBEEF);
    start(1, 32'h0000_0FFC, 1'b0, 0);
    wait_done(1);
    stop(1);
    @(negedge clk);
    chk("finish_set", {finish, finish_m}, 2'b11);
    push(0, 1'b0, 32'hDEADBEEF);
    start(0, 32'h0000_0FFC, 1'b0, 0);
    wait_done(0);
    stop(0);
    @(negedge clk);
    chk("finish_sticky", {finish, finish_m}, 2'b11);
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0;
    @(negedge clk);
    chk("finish_clear", finish, 0);
    ack_en[0] = 0;
    push(0, 1'b0, 32'hDEADBEEF);
    start(0, 32'h0000_0020, 1'b0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 core_sel = 0;
    @(negedge clk);
    chk("inflight_kept", b_cyc[0], 1);
    ack_en[0] = 1;
    wait_done(0);
    stop(0);
    push(2, 1'b0, 32'hCAFE0001);
    start(2, 32'h8000_0000, 1'b1, 32'h55AA);
    @(negedge clk); @(negedge clk);
    chk("host_grant", b_cyc, 2'b10);
    chk("host_we", b_we[1], 1);
    chk("host_wdata", b_wdata[63:32], 32'h55AA);
    wait_done(2);
    stop(2);
    push(2, 1'b0, 32'hDEADBEEF);
    start(2, 32'h0000_0FFC, 1'b0, 0);
    wait_done(2);
    stop(2);
    @(negedge clk);
    chk("host_no_finish", finish, 0);
    start(1, 32'h0000_0200, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("stall_ineligible", {b_cyc, m_ack}, 0);
    stop(1);
    ack_en[1] = 0;
    push(2, 1'b0, 32'h0);
    start(2, 32'h8000_0004, 1'b0, 0);
    @(negedge clk); @(negedge clk);
    chk("rst_pre_busy", b_cyc, 2'b10);
    #2 rst = 1;
    #1 chk("rst_async_drop", {b_cyc, b_stb, h_ack, h_err}, 0);
    exp_q[2].delete();
    stop(2);
    @(posedge clk); #1 rst = 0;
    ack_en[1] = 1;
    @(negedge clk);
    chk("post_rst_idle", {b_cyc, m_ack, h_ack, finish}, 0);
    chk("scoreboard_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
